rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port (I_en / I_rd / I_dataD of the register file) between two write-back requesters: ALU and load/store unit (LSU).
- Round-robin arbitration with valid/ready handshakes; one registered write per cycle to the register file.
- Holds a 32-entry pending-write scoreboard, so the issue stage can stall on read-after-write hazards for rs1/rs2.

---
 rtl/rf_wb_arbiter.sv | 100 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter (ALU vs LSU) for the single register-file write port,
// with a pending-write scoreboard for read-after-write hazard detection at issue.
module rf_wb_arbiter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            I_rst,
    input  logic            I_alu_valid,
    output logic            O_alu_ready,
    input  logic [AW-1:0]   I_alu_rd,
    input  logic [XLEN-1:0] I_alu_data,
    input  logic            I_lsu_valid,
    output logic            O_lsu_ready,
    input  logic [AW-1:0]   I_lsu_rd,
    input  logic [XLEN-1:0] I_lsu_data,
    input  logic            I_issue_en,
    input  logic [AW-1:0]   I_issue_rd,
    input  logic [AW-1:0]   I_rs1,
    input  logic [AW-1:0]   I_rs2,
    output logic            O_rs1_busy,
    output logic            O_rs2_busy,
    output logic            O_rf_en,
    output logic [AW-1:0]   O_rf_rd,
    output logic [XLEN-1:0] O_rf_data,
    output logic            O_grant_src
);
    localparam int unsigned NReg = 2 ** AW;

    logic            last_lsu_q;
    logic            rf_en_q;
    logic [AW-1:0]   rf_rd_q;
    logic [XLEN-1:0] rf_data_q;
    logic            grant_src_q;
    logic [NReg-1:0] pend_q;
    logic [NReg-1:0] pend_d;

    logic alu_ready;
    logic lsu_ready;
    logic alu_xfer;
    logic lsu_xfer;

    // Under contention the source that did not win last time is granted.
    always_comb begin
        alu_ready = I_alu_valid & (~I_lsu_valid | last_lsu_q);
        lsu_ready = I_lsu_valid & (~I_alu_valid | ~last_lsu_q);
        alu_xfer  = I_alu_valid & alu_ready;
        lsu_xfer  = I_lsu_valid & lsu_ready;
    end

    // Set is applied after clear so a same-edge newer writer keeps the bit.
    always_comb begin
        pend_d = pend_q;
        if (rf_en_q) begin
            pend_d[rf_rd_q] = 1'b0;
        end
        if (I_issue_en && (I_issue_rd != '0)) begin
            pend_d[I_issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (I_rst) begin
            last_lsu_q  <= 1'b1;
            rf_en_q     <= 1'b0;
            rf_rd_q     <= '0;
            rf_data_q   <= '0;
            grant_src_q <= 1'b0;
            pend_q      <= '0;
        end else begin
            pend_q <= pend_d;
            if (alu_xfer) begin
                rf_en_q     <= (I_alu_rd != '0);
                rf_rd_q     <= I_alu_rd;
                rf_data_q   <= I_alu_data;
                grant_src_q <= 1'b0;
                last_lsu_q  <= 1'b0;
            end else if (lsu_xfer) begin
                rf_en_q     <= (I_lsu_rd != '0);
                rf_rd_q     <= I_lsu_rd;
                rf_data_q   <= I_lsu_data;
                grant_src_q <= 1'b1;
                last_lsu_q  <= 1'b1;
            end else begin
                rf_en_q <= 1'b0;
            end
        end
    end

    assign O_alu_ready = alu_ready;
    assign O_lsu_ready = lsu_ready;
    assign O_rs1_busy  = pend_q[I_rs1] & (I_rs1 != '0);
    assign O_rs2_busy  = pend_q[I_rs2] & (I_rs2 != '0);
    assign O_rf_en     = rf_en_q;
    assign O_rf_rd     = rf_rd_q;
    assign O_rf_data   = rf_data_q;
    assign O_grant_src = grant_src_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a driver process predicts grants, busy bits and
// register-file writes from a reference model; a monitor process checks the write port.
module tb_rf_wb_arbiter;
    localparam int AW   = 5;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } req_t;

    typedef struct {
        int              cyc;
        logic            en;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic            src;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            alu_v, lsu_v, alu_rdy, lsu_rdy;
    logic [AW-1:0]   alu_rd, lsu_rd, iss_rd, rs1, rs2, rf_rd;
    logic [XLEN-1:0] alu_d, lsu_d, rf_data;
    logic            iss_en, rs1_busy, rs2_busy, rf_en, grant_src;

    rf_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .clk         (clk),
        .I_rst       (rst),
        .I_alu_valid (alu_v),
        .O_alu_ready (alu_rdy),
        .I_alu_rd    (alu_rd),
        .I_alu_data  (alu_d),
        .I_lsu_valid (lsu_v),
        .O_lsu_ready (lsu_rdy),
        .I_lsu_rd    (lsu_rd),
        .I_lsu_data  (lsu_d),
        .I_issue_en  (iss_en),
        .I_issue_rd  (iss_rd),
        .I_rs1       (rs1),
        .I_rs2       (rs2),
        .O_rs1_busy  (rs1_busy),
        .O_rs2_busy  (rs2_busy),
        .O_rf_en     (rf_en),
        .O_rf_rd     (rf_rd),
        .O_rf_data   (rf_data),
        .O_grant_src (grant_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Requester queues and expected write-port queue.
    req_t aq[$];
    req_t lq[$];
    exp_t exp_q[$];

    // Reference model: last winner (1 = LSU), pending bits, write in flight.
    bit              m_last = 1'b1;
    bit              m_pend[32];
    bit              m_wr_v = 1'b0;
    logic [AW-1:0]   m_wr_rd = '0;
    bit              mon_en = 1'b0;

    task automatic push_exp(input logic en, input logic [AW-1:0] rd,
                            input logic [XLEN-1:0] d, input logic src);
        exp_t e;
        e.cyc  = cyc + 1;
        e.en   = en;
        e.rd   = rd;
        e.data = d;
        e.src  = src;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic i_en, input logic [AW-1:0] i_rd, input logic [AW-1:0] r1,
                        input logic [AW-1:0] r2, input logic r);
        bit ea, el, nw_v;
        logic [AW-1:0] nw_rd;
        iss_en = i_en;
        iss_rd = i_rd;
        rs1    = r1;
        rs2    = r2;
        rst    = r;
        alu_v  = (aq.size() > 0);
        lsu_v  = (lq.size() > 0);
        if (alu_v) begin
            alu_rd = aq[0].rd;
            alu_d  = aq[0].data;
        end
        if (lsu_v) begin
            lsu_rd = lq[0].rd;
            lsu_d  = lq[0].data;
        end
        @(negedge clk);
        ea = alu_v && (!lsu_v || m_last);
        el = lsu_v && (!alu_v || !m_last);
        chk("alu_ready", {31'd0, alu_rdy}, {31'd0, ea});
        chk("lsu_ready", {31'd0, lsu_rdy}, {31'd0, el});
        chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, (r1 != 0) && m_pend[r1]});
        chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, (r2 != 0) && m_pend[r2]});
        nw_v  = 1'b0;
        nw_rd = '0;
        if (r) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_last = 1'b1;
            push_exp(1'b0, '0, '0, 1'b0);
        end else begin
            if (m_wr_v) m_pend[m_wr_rd] = 1'b0;
            if (i_en && i_rd != 0) m_pend[i_rd] = 1'b1;
            if (ea) begin
                m_last = 1'b0;
                push_exp(alu_rd != 0, alu_rd, alu_d, 1'b0);
                nw_v  = (alu_rd != 0);
                nw_rd = alu_rd;
            end else if (el) begin
                m_last = 1'b1;
                push_exp(lsu_rd != 0, lsu_rd, lsu_d, 1'b1);
                nw_v  = (lsu_rd != 0);
                nw_rd = lsu_rd;
            end
        end
        m_wr_v  = nw_v;
        m_wr_rd = nw_rd;
        @(posedge clk);
        #1;
        if (ea) void'(aq.pop_front());
        if (el) void'(lq.pop_front());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0);
    endtask

    // Monitor: write port must match the queue head when due, else idle and hold.
    logic [AW-1:0]   h_rd = '0;
    logic [XLEN-1:0] h_data = '0;
    logic            h_src = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rf_en", {31'd0, rf_en}, {31'd0, e.en});
                chk("rf_rd", {27'd0, rf_rd}, {27'd0, e.rd});
                chk("rf_data", rf_data, e.data);
                chk("grant_src", {31'd0, grant_src}, {31'd0, e.src});
                h_rd   = e.rd;
                h_data = e.data;
                h_src  = e.src;
            end else begin
                chk("rf_en_idle", {31'd0, rf_en}, 32'd0);
                chk("rf_rd_hold", {27'd0, rf_rd}, {27'd0, h_rd});
                chk("rf_data_hold", rf_data, h_data);
                chk("grant_src_hold", {31'd0, grant_src}, {31'd0, h_src});
            end
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL stale_expect: entry due cyc %0d still queued at %0d",
                         exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        alu_v = 0; lsu_v = 0; alu_rd = '0; lsu_rd = '0; alu_d = '0; lsu_d = '0;
        iss_en = 0; iss_rd = '0; rs1 = '0; rs2 = '0; rst = 1;
        foreach (m_pend[i]) m_pend[i] = 1'b0;

        // Reset, then ALU alone.
        step(1'b0, '0, '0, '0, 1'b1);
        mon_en = 1'b1;
        aq.push_back('{rd: 5'd7, data: 32'd1000});
        idle(3);

        // Contention straight from reset: ALU first, then LSU.
        step(1'b0, '0, '0, '0, 1'b1);
        aq.push_back('{rd: 5'd5, data: 32'd10001});
        lq.push_back('{rd: 5'd4, data: 32'd10011});
        idle(3);

        // Sustained contention: strict alternation, no idle cycle.
        for (int i = 0; i < 6; i++) begin
            aq.push_back('{rd: 5'(i + 1), data: $urandom()});
            lq.push_back('{rd: 5'(i + 10), data: $urandom()});
        end
        idle(14);

        // Scoreboard: issue rd5, LSU writes rd5 later.
        step(1'b1, 5'd5, '0, '0, 1'b0);
        step(1'b0, '0, 5'd5, 5'd4, 1'b0);
        lq.push_back('{rd: 5'd5, data: 32'hCAFE_0005});
        for (int i = 0; i < 3; i++) step(1'b0, '0, 5'd5, 5'd4, 1'b0);

        // rd0 write and rd0 issue.
        aq.push_back('{rd: 5'd0, data: 32'hFFFF_FFFF});
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        step(1'b0, '0, 5'd0, 5'd0, 1'b0);

        // Same-edge set and clear of rd9, then reset while a write is registered.
        step(1'b1, 5'd9, 5'd9, '0, 1'b0);
        aq.push_back('{rd: 5'd9, data: 32'h9999});
        step(1'b0, '0, 5'd9, '0, 1'b0);
        step(1'b1, 5'd9, 5'd9, '0, 1'b0);
        step(1'b0, '0, 5'd9, '0, 1'b0);
        aq.push_back('{rd: 5'd3, data: 32'h3333});
        step(1'b1, 5'd12, 5'd12, 5'd9, 1'b0);
        step(1'b0, '0, 5'd12, 5'd9, 1'b1);
        step(1'b0, '0, 5'd12, 5'd9, 1'b0);
        step(1'b0, '0, 5'd3, 5'd9, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            logic          ie;
            logic [AW-1:0] ird;
            if (aq.size() < 3 && $urandom_range(0, 2) != 0)
                aq.push_back('{rd: 5'($urandom_range(0, 31)), data: $urandom()});
            if (lq.size() < 3 && $urandom_range(0, 2) != 0)
                lq.push_back('{rd: 5'($urandom_range(0, 31)), data: $urandom()});
            ird = 5'($urandom_range(0, 31));
            ie  = ($urandom_range(0, 1) == 1) && !m_pend[ird];
            step(ie, ird, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 $urandom_range(0, 59) == 0);
        end
        aq.delete();
        lq.delete();
        idle(4);
        chk("exp_q_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
